// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (8 ops incl. signed saturation) with zero/neg/carry/ovf flags and a sideband tag.
// Latency 2 cycles, one op/cycle; stalls hold both stages and in_ready drops when both are full and blocked.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_ADDS = 3'd6;
  localparam logic [2:0] OP_SUBS = 3'd7;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_v;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_v;
  logic [WIDTH-1:0] s2_res;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_zero;
  logic             s2_neg;
  logic             s2_carry;
  logic             s2_ovf;

  logic             s2_load;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] c_res;
  logic             c_carry;
  logic             c_ovf;

  assign s2_load  = !s2_v || out_ready;
  assign in_ready = !s1_v || s2_load;

  assign out_valid = s2_v;
  assign out_res   = s2_res;
  assign out_tag   = s2_tag;
  assign out_zero  = s2_zero;
  assign out_neg   = s2_neg;
  assign out_carry = s2_carry;
  assign out_ovf   = s2_ovf;

  // Extra MSB gives the unsigned carry-out (add) and borrow (sub).
  assign sum_w  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_w = {1'b0, s1_a} - {1'b0, s1_b};

  assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_w[WIDTH-1]  != s1_a[WIDTH-1]);
  assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff_w[WIDTH-1] != s1_a[WIDTH-1]);

  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        c_res   = sum_w[WIDTH-1:0];
        c_carry = sum_w[WIDTH];
        c_ovf   = add_ovf;
      end
      OP_SUB: begin
        c_res   = diff_w[WIDTH-1:0];
        c_carry = !diff_w[WIDTH];
        c_ovf   = sub_ovf;
      end
      OP_AND: c_res = s1_a & s1_b;
      OP_OR:  c_res = s1_a | s1_b;
      OP_XOR: c_res = s1_a ^ s1_b;
      OP_SLT: c_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      // On signed overflow the true result's sign is that of operand a.
      OP_ADDS: begin
        c_res   = add_ovf ? (s1_a[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum_w[WIDTH-1:0];
        c_carry = sum_w[WIDTH];
        c_ovf   = add_ovf;
      end
      OP_SUBS: begin
        c_res   = sub_ovf ? (s1_a[WIDTH-1] ? SAT_MIN : SAT_MAX) : diff_w[WIDTH-1:0];
        c_carry = !diff_w[WIDTH];
        c_ovf   = sub_ovf;
      end
      default: c_res = '0;
    endcase
  end

  // in_ready already implies stage 1 is empty or draining into stage 2 this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_op  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      s2_res   <= '0;
      s2_tag   <= '0;
      s2_zero  <= 1'b0;
      s2_neg   <= 1'b0;
      s2_carry <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_res   <= c_res;
        s2_tag   <= s1_tag;
        s2_zero  <= (c_res == '0);
        s2_neg   <= c_res[WIDTH-1];
        s2_carry <= c_carry;
        s2_ovf   <= c_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: single ops with hand-computed results, streaming, backpressure and mid-stream reset.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic [TW-1:0] out_tag;
  logic          out_zero;
  logic          out_neg;
  logic          out_carry;
  logic          out_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Flags compared as {zero, neg, carry, ovf}.
  task automatic single(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
    cyc();
    out_ready = 1'b1;
    drive(op, a, b, tag);
    mid();
    chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    mid();
    chk({name, ".early"}, 32'(out_valid), 32'd0);
    cyc();
    mid();
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".res"}, out_res, exp_res);
    chk({name, ".tag"}, 32'(out_tag), 32'(tag));
    chk({name, ".flags"}, 32'({out_zero, out_neg, out_carry, out_ovf}), 32'(exp_flags));
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    #1 rst_n = 1'b0;
    mid();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.res", out_res, 32'd0);
    chk("rst.tag", 32'(out_tag), 32'd0);
    chk("rst.flags", 32'({out_zero, out_neg, out_carry, out_ovf}), 32'd0);
    mid();
    rst_n = 1'b1;

    single("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h1, 4'd3, 32'h8000_0000, 4'b0101);
    single("sub_eq",  3'd1, 32'd5, 32'd5, 4'd1, 32'h0, 4'b1010);
    single("sub_neg", 3'd1, 32'd3, 32'd5, 4'd2, 32'hFFFF_FFFE, 4'b0100);
    single("slt",     3'd5, 32'hFFFF_FFFF, 32'h1, 4'd4, 32'h1, 4'b0000);
    single("adds_sat", 3'd6, 32'h7FFF_FFF0, 32'h100, 4'd5, 32'h7FFF_FFFF, 4'b0001);
    single("subs_sat", 3'd7, 32'h8000_0000, 32'h1, 4'd6, 32'h8000_0000, 4'b0111);
    single("adds_ok", 3'd6, 32'd2, 32'd3, 4'd7, 32'd5, 4'b0000);
    single("and", 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd8, 32'h00F0_00F0, 4'b0000);
    single("or",  3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9, 32'hFFF0_FFF0, 4'b0100);
    single("xor", 3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd10, 32'hFF00_FF00, 4'b0100);

    // Streaming: op i presented in cycle i must come out in cycle i+2.
    cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) cyc();
      if (c < 8) drive(3'd0, 32'(c), 32'h100, 4'(c));
      else in_valid = 1'b0;
      mid();
      if (c < 8) chk("b2b.in_ready", 32'(in_ready), 32'd1);
      if (c >= 2 && c < 10) begin
        chk("b2b.valid", 32'(out_valid), 32'd1);
        chk("b2b.tag", 32'(out_tag), 32'(c - 2));
        chk("b2b.res", out_res, 32'(c - 2) + 32'h100);
      end else begin
        chk("b2b.idle", 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: tags 0..3 offered back to back, consumer stalled for 4 cycles.
    begin
      int nxt;
      int exp_out;
      nxt     = 0;
      exp_out = 0;
      cyc();
      out_ready = 1'b0;
      for (int c = 0; c < 9; c++) begin
        if (c > 0) cyc();
        if (c == 4) out_ready = 1'b1;
        if (nxt < 4) drive(3'd0, 32'(nxt) * 32'h10, 32'h1, 4'(nxt));
        else in_valid = 1'b0;
        mid();
        if (c < 2 || c >= 4) chk("bp.in_ready", 32'(in_ready), 32'd1);
        else chk("bp.in_ready_low", 32'(in_ready), 32'd0);
        if (c < 2 || c == 8) begin
          chk("bp.idle", 32'(out_valid), 32'd0);
        end else begin
          chk("bp.valid", 32'(out_valid), 32'd1);
          chk("bp.tag", 32'(out_tag), 32'(exp_out));
          chk("bp.res", out_res, 32'(exp_out) * 32'h10 + 32'h1);
          if (out_ready) exp_out++;
        end
        if (in_valid && in_ready) nxt++;
      end
      chk("bp.accepted", 32'(nxt), 32'd4);
      chk("bp.emitted", 32'(exp_out), 32'd4);
    end

    // Reset with both stages occupied.
    cyc();
    out_ready = 1'b0;
    drive(3'd3, 32'h1234_0000, 32'h0000_5678, 4'd11);
    cyc();
    drive(3'd0, 32'h1, 32'h1, 4'd12);
    cyc();
    in_valid = 1'b0;
    mid();
    chk("rstmid.full_valid", 32'(out_valid), 32'd1);
    chk("rstmid.full_res", out_res, 32'h1234_5678);
    chk("rstmid.full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.valid", 32'(out_valid), 32'd0);
    chk("rstmid.res", out_res, 32'd0);
    chk("rstmid.tag", 32'(out_tag), 32'd0);
    chk("rstmid.flags", 32'({out_zero, out_neg, out_carry, out_ovf}), 32'd0);
    chk("rstmid.in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      mid();
      chk("post_rst.valid", 32'(out_valid), 32'd0);
      chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
